// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings, responder FSM states and the GPIO register map.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} ahb_state_t;

    localparam logic [4:0] OFS_OUT      = 5'h00;
    localparam logic [4:0] OFS_DIR      = 5'h04;
    localparam logic [4:0] OFS_IN       = 5'h08;
    localparam logic [4:0] OFS_SET      = 5'h0C;
    localparam logic [4:0] OFS_CLR      = 5'h10;
    localparam logic [4:0] OFS_IRQ_EN   = 5'h14;
    localparam logic [4:0] OFS_IRQ_STAT = 5'h18;

    // Bit mask of the byte lanes touched by a transfer of the given size and address.
    function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0]  lanes;
        logic [31:0] mask;
        case (size)
            HSIZE_BYTE:  lanes = 4'b0001 << addr;
            HSIZE_HWORD: lanes = addr[1] ? 4'b1100 : 4'b0011;
            default:     lanes = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{lanes[i]}};
        return mask;
    endfunction

endpackage

// File: rtl/gc_sync_edge.sv
// Multi-stage input synchroniser followed by a previous-value register for rising-edge detect.
module gc_sync_edge #(
    parameter int g_width  = 8,
    parameter int g_stages = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [g_width-1:0] din,
    output logic [g_width-1:0] sync,
    output logic [g_width-1:0] rise
);

    logic [g_stages-1:0][g_width-1:0] chain_q;
    logic [g_width-1:0]               prev_q;

    // NOTE: non-blocking assignments let each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[g_stages-2:0], din};
            prev_q  <= chain_q[g_stages-1];
        end
    end

    assign sync = chain_q[g_stages-1];
    assign rise = sync & ~prev_q;

endmodule

// File: rtl/ahb3lite_gpio_slave.sv
// AHB3-Lite GPIO responder: OUT/DIR/IN/SET/CLR/IRQ registers, programmable wait states,
// two-cycle ERROR response for illegal accesses.
module ahb3lite_gpio_slave
    import ahb3lite_pkg::*;
#(
    parameter int g_haddr_width = 32,
    parameter int g_hdata_width = 32,
    parameter int g_gpio_width  = 8,
    parameter int g_wait_states = 0,
    parameter int g_sync_stages = 2
) (
    input  logic                     hclk_i,
    input  logic                     hreset_n_i,
    input  logic                     hsel_i,
    input  logic [g_haddr_width-1:0] haddr_i,
    input  logic [g_hdata_width-1:0] hwdata_i,
    output logic [g_hdata_width-1:0] hrdata_o,
    input  logic                     hwrite_i,
    input  logic [2:0]               hsize_i,
    input  logic [2:0]               hburst_i,
    input  logic [3:0]               hprot_i,
    input  logic [1:0]               htrans_i,
    input  logic                     hmastlock_i,
    input  logic                     hready_i,
    output logic                     hreadyout_o,
    output logic                     hresp_o,
    input  logic [g_gpio_width-1:0]  gpio_i,
    output logic [g_gpio_width-1:0]  gpio_o,
    output logic [g_gpio_width-1:0]  gpio_oe_o,
    output logic                     irq_o
);

    localparam logic [3:0] WAIT_LOAD = (g_wait_states > 0) ? 4'(g_wait_states - 1) : 4'd0;

    ahb_state_t              state_q;
    logic [3:0]              wait_cnt_q;
    logic                    dp_valid_q, dp_write_q;
    logic [4:0]              dp_addr_q;
    logic [2:0]              dp_size_q;
    logic [g_gpio_width-1:0] out_q, dir_q, ien_q, stat_q, stat_next;
    logic [g_gpio_width-1:0] gpio_sync, gpio_rise, wdat_g, w1c;
    logic                    irq_q, accept, illegal, completing, wr_commit;
    logic [4:0]              req_word, dp_word;
    logic [31:0]             wmask;
    logic [g_hdata_width-1:0] rd_word;
    logic                    unused_bits;

    gc_sync_edge #(
        .g_width (g_gpio_width),
        .g_stages(g_sync_stages)
    ) u_sync (
        .clk  (hclk_i),
        .rst_n(hreset_n_i),
        .din  (gpio_i),
        .sync (gpio_sync),
        .rise (gpio_rise)
    );

    assign accept   = hsel_i & hready_i & htrans_i[1] & (state_q == ST_IDLE || state_q == ST_ERR2);
    assign req_word = {haddr_i[4:2], 2'b00};
    assign illegal  = (req_word > OFS_IRQ_STAT)
                    || (hwrite_i && req_word == OFS_IN)
                    || (hsize_i > HSIZE_WORD)
                    || (hsize_i == HSIZE_HWORD && haddr_i[0])
                    || (hsize_i == HSIZE_WORD && haddr_i[1:0] != 2'b00);

    // The completing data phase is an ST_IDLE cycle that still holds a legal transfer.
    assign completing = (state_q == ST_IDLE) && dp_valid_q;
    assign wr_commit  = completing && dp_write_q;
    assign dp_word    = {dp_addr_q[4:2], 2'b00};
    assign wmask      = lane_mask(dp_size_q, dp_addr_q[1:0]);
    assign wdat_g     = hwdata_i[g_gpio_width-1:0] & wmask[g_gpio_width-1:0];
    assign w1c        = (wr_commit && dp_word == OFS_IRQ_STAT) ? wdat_g : '0;
    assign stat_next  = (stat_q & ~w1c) | gpio_rise;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        rd_word = '0;
        case (dp_word)
            OFS_OUT:      rd_word[g_gpio_width-1:0] = out_q;
            OFS_DIR:      rd_word[g_gpio_width-1:0] = dir_q;
            OFS_IN:       rd_word[g_gpio_width-1:0] = gpio_sync;
            OFS_IRQ_EN:   rd_word[g_gpio_width-1:0] = ien_q;
            OFS_IRQ_STAT: rd_word[g_gpio_width-1:0] = stat_q;
            default:      rd_word = '0;
        endcase
    end

    assign hrdata_o = (completing && !dp_write_q) ? rd_word : '0;

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            state_q     <= ST_IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= HRESP_OKAY;
            wait_cnt_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_addr_q   <= '0;
            dp_size_q   <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q     <= ST_IDLE;
                        hreadyout_o <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_o <= 1'b1;
                    hresp_o     <= HRESP_OKAY;
                    dp_valid_q  <= 1'b0;
                    if (accept) begin
                        dp_addr_q  <= haddr_i[4:0];
                        dp_write_q <= hwrite_i;
                        dp_size_q  <= hsize_i;
                        if (illegal) begin
                            state_q     <= ST_ERR1;
                            hreadyout_o <= 1'b0;
                            hresp_o     <= HRESP_ERROR;
                        end else begin
                            dp_valid_q <= 1'b1;
                            if (g_wait_states != 0) begin
                                state_q     <= ST_WAIT;
                                hreadyout_o <= 1'b0;
                                wait_cnt_q  <= WAIT_LOAD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge hclk_i or negedge hreset_n_i) begin
        if (!hreset_n_i) begin
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_next;
            irq_q  <= |(stat_q & ien_q);
            if (wr_commit) begin
                case (dp_word)
                    OFS_OUT:    out_q <= (out_q & ~wmask[g_gpio_width-1:0]) | wdat_g;
                    OFS_DIR:    dir_q <= (dir_q & ~wmask[g_gpio_width-1:0]) | wdat_g;
                    OFS_SET:    out_q <= out_q | wdat_g;
                    OFS_CLR:    out_q <= out_q & ~wdat_g;
                    OFS_IRQ_EN: ien_q <= (ien_q & ~wmask[g_gpio_width-1:0]) | wdat_g;
                    default:    ;
                endcase
            end
        end
    end

    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;

    assign unused_bits = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0],
                           haddr_i[g_haddr_width-1:5], hwdata_i, wmask};

endmodule

// File: tb/tb_ahb3lite_gpio_slave.sv
// Scoreboard bench: zero-wait instance for the register map, a 3-wait instance for wait/reset timing.
module tb_ahb3lite_gpio_slave;
    import ahb3lite_pkg::*;

    logic        hclk = 1'b0;
    logic        hreset_n, rst3_n, hsel0, hsel3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [7:0]  gpio_i;

    logic [31:0] hrdata0, hrdata3;
    logic        hro0, hresp0, irq0, hro3, hresp3, irq3;
    logic [7:0]  gpio_o0, oe0, gpio_o3, oe3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 hclk = ~hclk;

    ahb3lite_gpio_slave dut0 (
        .hclk_i(hclk), .hreset_n_i(hreset_n), .hsel_i(hsel0), .haddr_i(haddr),
        .hwdata_i(hwdata), .hrdata_o(hrdata0), .hwrite_i(hwrite), .hsize_i(hsize),
        .hburst_i(3'b000), .hprot_i(4'b0000), .htrans_i(htrans), .hmastlock_i(1'b0),
        .hready_i(hro0), .hreadyout_o(hro0), .hresp_o(hresp0), .gpio_i(gpio_i),
        .gpio_o(gpio_o0), .gpio_oe_o(oe0), .irq_o(irq0)
    );

    ahb3lite_gpio_slave #(.g_wait_states(3)) dut3 (
        .hclk_i(hclk), .hreset_n_i(rst3_n), .hsel_i(hsel3), .haddr_i(haddr),
        .hwdata_i(hwdata), .hrdata_o(hrdata3), .hwrite_i(hwrite), .hsize_i(hsize),
        .hburst_i(3'b000), .hprot_i(4'b0000), .htrans_i(htrans), .hmastlock_i(1'b0),
        .hready_i(hro3), .hreadyout_o(hro3), .hresp_o(hresp3), .gpio_i(gpio_i),
        .gpio_o(gpio_o3), .gpio_oe_o(oe3), .irq_o(irq3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        bit          wr;
        bit          err;
        int          waits;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    logic ph0;
    int   wt0 = 0;
    logic resp_first0 = 1'b0;

    // Data-phase tracker for dut0: a transfer is in its data phase after an accepted address phase.
    always @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) ph0 <= 1'b0;
        else if (hro0) ph0 <= hsel0 & htrans[1];
    end

    always @(negedge hclk) begin
        exp_t e;
        if (hreset_n && ph0) begin
            if (!hro0) begin
                if (wt0 == 0) resp_first0 = hresp0;
                wt0++;
            end else begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_wait"}, wt0, e.waits);
                    check({e.tag, "_resp"}, {31'd0, hresp0}, {31'd0, e.err});
                    if (e.err) check({e.tag, "_resp1"}, {31'd0, resp_first0}, 32'd1);
                    if (!e.wr && !e.err) check({e.tag, "_rd"}, hrdata0, e.rd);
                end
                wt0 = 0;
            end
        end
    end

    task automatic issue(input string tag, input logic [31:0] addr, input bit wr,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_err, output int cyc);
        exp_t e;
        bit   rdy;
        e.tag = tag; e.wr = wr; e.err = exp_err; e.waits = exp_err ? 1 : 0; e.rd = exp_rd;
        sb.push_back(e);
        hsel0 = 1'b1; haddr = addr; hwrite = wr; hsize = sz; htrans = HTRANS_NONSEQ;
        cyc = 0;
        do begin
            @(negedge hclk);
            rdy = hro0;
            @(posedge hclk);
            cyc++;
        end while (!rdy && cyc < 50);
        if (!rdy) check({tag, "_accept"}, 32'd0, 32'd1);
        #1 hwdata = wd;
    endtask

    task automatic drain();
        int n = 0;
        hsel0 = 1'b0; htrans = HTRANS_IDLE;
        while ((sb.size() != 0 || ph0) && n < 100) begin
            @(posedge hclk); #1; n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int cyc, low;
        bit done;
        hreset_n = 1'b1; rst3_n = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0;
        haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_IDLE;
        gpio_i = 8'h3C;
        #2 hreset_n = 1'b0; rst3_n = 1'b0;
        #10;
        check("rst_hready", {31'd0, hro0}, 32'd1);
        check("rst_hresp", {31'd0, hresp0}, 32'd0);
        check("rst_hrdata", hrdata0, 32'd0);
        check("rst_gpio_o", {24'd0, gpio_o0}, 32'd0);
        check("rst_oe", {24'd0, oe0}, 32'd0);
        check("rst_irq", {31'd0, irq0}, 32'd0);
        check("rst3_misc", {hro3, hresp3, irq3, gpio_o3, oe3}, {1'b1, 18'd0});
        @(posedge hclk); #1 hreset_n = 1'b1; rst3_n = 1'b1;
        repeat (4) @(posedge hclk);
        #1;

        // Basic write/read
        issue("t1_wout", 32'h00, 1, HSIZE_WORD, 32'h0000_00A5, 0, 0, cyc);
        issue("t1_wdir", 32'h04, 1, HSIZE_WORD, 32'h0000_00FF, 0, 0, cyc);
        issue("t1_rout", 32'h00, 0, HSIZE_WORD, 0, 32'h0000_00A5, 0, cyc);
        drain();
        check("t1_gpio_o", {24'd0, gpio_o0}, 32'hA5);
        check("t1_oe", {24'd0, oe0}, 32'hFF);

        // SET/CLR and a byte lane above the GPIO width
        issue("t2_set", 32'h0C, 1, HSIZE_WORD, 32'h0A, 0, 0, cyc);
        issue("t2_clr", 32'h10, 1, HSIZE_WORD, 32'h81, 0, 0, cyc);
        issue("t2_byte1", 32'h01, 1, HSIZE_BYTE, 32'h5A5A_5A5A, 0, 0, cyc);
        issue("t2_rout", 32'h00, 0, HSIZE_WORD, 0, 32'h2E, 0, cyc);
        issue("t2_rset", 32'h0C, 0, HSIZE_WORD, 0, 32'h0, 0, cyc);
        drain();
        check("t2_gpio_o", {24'd0, gpio_o0}, 32'h2E);

        // Back-to-back write then read with no bubble
        issue("t3_wout", 32'h00, 1, HSIZE_WORD, 32'h11, 0, 0, cyc);
        issue("t3_rin", 32'h08, 0, HSIZE_WORD, 0, 32'h3C, 0, cyc);
        check("t3_nobubble", cyc, 32'd1);
        issue("t3_rout", 32'h00, 0, HSIZE_WORD, 0, 32'h11, 0, cyc);
        drain();

        // Wait states on the 3-wait instance
        hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h08; hwrite = 1'b0; hsize = HSIZE_WORD;
        @(posedge hclk); #1 hsel3 = 1'b0; htrans = HTRANS_IDLE;
        low = 0; done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge hclk);
            if (!hro3) begin
                if (low == 0) check("t4_rd_zero", hrdata3, 32'd0);
                low++;
            end else begin
                check("t4_rdata", hrdata3, 32'h3C);
                check("t4_resp", {31'd0, hresp3}, 32'd0);
                done = 1'b1;
            end
        end
        check("t4_waits", low, 32'd3);
        check("t4_done", {31'd0, done}, 32'd1);
        @(posedge hclk); #1;
        hsel3 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00;
        @(posedge hclk); #1 hsel3 = 1'b0; htrans = HTRANS_IDLE;
        @(posedge hclk); #2;
        check("t4_wait2_low", {31'd0, hro3}, 32'd0);
        rst3_n = 1'b0;
        #1;
        check("t4_rst_hready", {31'd0, hro3}, 32'd1);
        check("t4_rst_out", {hresp3, irq3, hrdata3}, 34'd0);
        @(posedge hclk); #1 rst3_n = 1'b1;
        @(posedge hclk); #1;

        // ERROR responses; following transfers are accepted in ST_ERR2
        issue("t5_r1c", 32'h1C, 0, HSIZE_WORD, 0, 0, 1, cyc);
        issue("t5_win", 32'h08, 1, HSIZE_WORD, 32'hFF, 0, 1, cyc);
        issue("t5_hw01", 32'h01, 1, HSIZE_HWORD, 32'hFFFF_FFFF, 0, 1, cyc);
        issue("t5_sz3", 32'h00, 1, 3'd3, 32'hFF, 0, 1, cyc);
        issue("t5_rout", 32'h00, 0, HSIZE_WORD, 0, 32'h11, 0, cyc);
        issue("t5_rdir", 32'h04, 0, HSIZE_WORD, 0, 32'hFF, 0, cyc);
        drain();

        // Interrupts
        issue("t6_w1c_all", 32'h18, 1, HSIZE_WORD, 32'hFF, 0, 0, cyc);
        issue("t6_ien", 32'h14, 1, HSIZE_WORD, 32'h01, 0, 0, cyc);
        issue("t6_rstat0", 32'h18, 0, HSIZE_WORD, 0, 32'h00, 0, cyc);
        drain();
        check("t6_irq_idle", {31'd0, irq0}, 32'd0);
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk) check("t6_irq_lat0", {31'd0, irq0}, 32'd0);
        @(negedge hclk) check("t6_irq_lat1", {31'd0, irq0}, 32'd1);
        @(posedge hclk); #1 gpio_i[0] = 1'b0;
        issue("t6_rstat1", 32'h18, 0, HSIZE_WORD, 0, 32'h01, 0, cyc);
        drain();
        repeat (4) @(posedge hclk);
        #1 gpio_i[0] = 1'b1;
        @(posedge hclk); #1;
        issue("t6_w1c_edge", 32'h18, 1, HSIZE_WORD, 32'h01, 0, 0, cyc);
        issue("t6_rstat_set", 32'h18, 0, HSIZE_WORD, 0, 32'h01, 0, cyc);
        drain();
        check("t6_irq_kept", {31'd0, irq0}, 32'd1);
        issue("t6_w1c", 32'h18, 1, HSIZE_WORD, 32'h01, 0, 0, cyc);
        issue("t6_rstat_clr", 32'h18, 0, HSIZE_WORD, 0, 32'h00, 0, cyc);
        drain();
        @(negedge hclk) check("t6_irq_clr", {31'd0, irq0}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
